// File: rtl/sap1_pkg.sv
// Shared widths and loader state encoding for the SAP-1 program RAM loader.
package sap1_pkg;
  localparam int ADDR_W    = 4;
  localparam int DATA_W    = 8;
  localparam int RAM_DEPTH = 16;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_FILL,
    LD_WRITE,
    LD_VERIFY,
    LD_DONE,
    LD_ERROR
  } ld_state_t;

  function automatic logic is_last(input logic [ADDR_W-1:0] a);
    return a == ADDR_W'(RAM_DEPTH - 1);
  endfunction
endpackage

// File: rtl/ram_loader.sv
// Streams 16 program bytes into RAM (one per 2 cycles), then optionally reads them back over the bus.
// Fill stalls while in_valid is low; start-to-done is 49 cycles with verify, abort wins over everything.
module ram_loader
  import sap1_pkg::*;
#(
  parameter int VERIFY_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              prg_mode,
  output logic [DATA_W-1:0] prg_data,
  output logic [ADDR_W-1:0] address,
  output logic              wr_en,
  output logic              re_en,
  input  logic [DATA_W-1:0] bus_in,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] err_addr
);

  ld_state_t         state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] shadow [RAM_DEPTH];
  logic              take;

  assign take = (state == LD_FILL) && in_valid && in_ready && !abort;

  // Copy of every byte handed to RAM, used as the verify reference.
  always_ff @(posedge clk) begin
    if (take) shadow[cnt] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= LD_IDLE;
      cnt      <= '0;
      in_ready <= 1'b0;
      prg_mode <= 1'b0;
      prg_data <= '0;
      address  <= '0;
      wr_en    <= 1'b0;
      re_en    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      err_addr <= '0;
    end else if (abort) begin
      // Sampled on the accepting edge, abort also keeps that byte's write strobe from ever issuing.
      state    <= LD_IDLE;
      cnt      <= '0;
      in_ready <= 1'b0;
      prg_mode <= 1'b0;
      prg_data <= '0;
      address  <= '0;
      wr_en    <= 1'b0;
      re_en    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      err_addr <= '0;
    end else begin
      case (state)
        LD_IDLE, LD_DONE, LD_ERROR: begin
          if (start) begin
            state    <= LD_FILL;
            cnt      <= '0;
            in_ready <= 1'b1;
            prg_mode <= 1'b1;
            prg_data <= '0;
            address  <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
            err_addr <= '0;
          end
        end
        LD_FILL: begin
          if (in_valid && in_ready) begin
            state    <= LD_WRITE;
            prg_data <= in_data;
            address  <= cnt;
            wr_en    <= 1'b1;
            in_ready <= 1'b0;
          end
        end
        LD_WRITE: begin
          wr_en <= 1'b0;
          if (!is_last(cnt)) begin
            state    <= LD_FILL;
            cnt      <= cnt + 1'b1;
            in_ready <= 1'b1;
          end else if (VERIFY_EN != 0) begin
            state    <= LD_VERIFY;
            cnt      <= '0;
            address  <= '0;
            prg_mode <= 1'b0;
            re_en    <= 1'b1;
          end else begin
            state    <= LD_DONE;
            prg_mode <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
          end
        end
        LD_VERIFY: begin
          if (bus_in != shadow[cnt]) begin
            state    <= LD_ERROR;
            err_addr <= cnt;
            re_en    <= 1'b0;
            busy     <= 1'b0;
            error    <= 1'b1;
          end else if (is_last(cnt)) begin
            state <= LD_DONE;
            re_en <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt     <= cnt + 1'b1;
            address <= cnt + 1'b1;
          end
        end
        default: state <= LD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
// Directed load scenarios with randomized data/stalls, checked against a RAM/timing model.
module tb_ram_loader;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, abort = 1'b0, in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, prg_mode, wr_en, re_en, busy, done, error;
  logic [7:0] prg_data, bus_in;
  logic [3:0] address, err_addr;

  logic       start1 = 1'b0, abort1 = 1'b0, in_valid1 = 1'b0;
  logic [7:0] in_data1 = 8'h00, bus_in1 = 8'h00;
  logic       in_ready1, prg_mode1, wr_en1, re_en1, busy1, done1, error1;
  logic [7:0] prg_data1;
  logic [3:0] address1, err_addr1;

  logic [7:0] tb_ram [16];
  logic       corrupt_en = 1'b0;
  logic [7:0] bytes [16];
  int         stall [16];
  int         wr_addr_q[$], wr_dat_q[$], wr_cyc_q[$], rd_q[$];
  int         overlap = 0;
  int         checks = 0, failures = 0;

  always #5 clk = ~clk;

  ram_loader #(.VERIFY_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .prg_mode(prg_mode), .prg_data(prg_data), .address(address),
    .wr_en(wr_en), .re_en(re_en), .bus_in(bus_in),
    .busy(busy), .done(done), .error(error), .err_addr(err_addr)
  );

  ram_loader #(.VERIFY_EN(0)) dut_nv (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .in_valid(in_valid1), .in_data(in_data1), .in_ready(in_ready1),
    .prg_mode(prg_mode1), .prg_data(prg_data1), .address(address1),
    .wr_en(wr_en1), .re_en(re_en1), .bus_in(bus_in1),
    .busy(busy1), .done(done1), .error(error1), .err_addr(err_addr1)
  );

  // Program RAM and shared bus: RAM drives the bus while re_en, optionally corrupting address 7.
  always @(posedge clk) if (wr_en) tb_ram[address] <= prg_data;
  assign bus_in = re_en ? ((corrupt_en && address == 4'd7) ? 8'hFF : tb_ram[address]) : 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Source offers byte i after stall[i] idle cycles; the loader needs 2 cycles per byte.
  function automatic int accept_cycle(input int i);
    int acc = 1;
    for (int k = 1; k <= i; k++) acc += (stall[k] + 1 > 2) ? stall[k] + 1 : 2;
    return acc;
  endfunction

  task automatic run_load(input int abort_idx, input int rst_addr, input int start_hold,
                          output int n_end);
    int idx = 0, sl = stall[0], n = 0, post = 0;
    bit fin = 0;
    n_end = 0;
    wr_addr_q.delete(); wr_dat_q.delete(); wr_cyc_q.delete(); rd_q.delete();
    @(negedge clk);
    start = 1'b1; in_valid = 1'b0; abort = 1'b0;
    while (post < 4 && n < 600) begin
      @(negedge clk);
      n++;
      if (wr_en) begin
        wr_addr_q.push_back(int'(address)); wr_dat_q.push_back(int'(prg_data));
        wr_cyc_q.push_back(n);
      end
      if (re_en) rd_q.push_back(int'(address));
      if (wr_en && re_en) overlap++;
      abort = 1'b0;
      if (!fin) begin
        if (done || error) begin
          fin = 1; n_end = n;
        end else if (rst_addr >= 0 && re_en && int'(address) == rst_addr) begin
          #2 rst_n = 1'b0;
          #1;
          check("rst_re_en_async", 32'(re_en), 0);
          check("rst_prg_mode_async", 32'(prg_mode), 0);
          check("rst_busy_async", 32'(busy), 0);
          fin = 1; n_end = n;
          @(negedge clk) rst_n = 1'b1;
        end
      end
      start = (!fin && n <= start_hold);
      if (!fin && idx < 16) begin
        if (sl > 0) begin
          in_valid = 1'b0; sl--;
        end else begin
          in_valid = 1'b1; in_data = bytes[idx];
        end
        if (in_valid && in_ready) begin
          if (idx == abort_idx) begin
            abort = 1'b1; fin = 1; n_end = n;
          end
          idx++;
          if (idx < 16) sl = stall[idx];
        end
      end else begin
        in_valid = 1'b0;
      end
      if (fin) post++;
    end
    check("load_finished", 32'(fin), 1);
    start = 1'b0; in_valid = 1'b0; abort = 1'b0;
  endtask

  task automatic check_writes(input int nw);
    check("wr_count", 32'(wr_addr_q.size()), 32'(nw));
    for (int i = 0; i < nw && i < wr_addr_q.size(); i++) begin
      check($sformatf("wr_addr[%0d]", i), 32'(wr_addr_q[i]), 32'(i));
      check($sformatf("wr_data[%0d]", i), 32'(wr_dat_q[i]), 32'(bytes[i]));
      check($sformatf("wr_cycle[%0d]", i), 32'(wr_cyc_q[i]), 32'(accept_cycle(i) + 1));
    end
  endtask

  task automatic check_reads(input int nr);
    check("rd_count", 32'(rd_q.size()), 32'(nr));
    for (int i = 0; i < nr && i < rd_q.size(); i++)
      check($sformatf("rd_addr[%0d]", i), 32'(rd_q[i]), 32'(i));
  endtask

  initial begin
    int n_end, n, w, last_w, re_seen, a5_ok;

    // Reset state of both instances
    #3;
    check("rst_ctrl", 32'({in_ready, prg_mode, wr_en, re_en, busy, done, error}), 0);
    check("rst_addr_data", 32'({address, err_addr, prg_data}), 0);
    check("rst_nv_all", 32'({in_ready1, prg_mode1, wr_en1, re_en1, busy1, done1, error1,
                             address1, err_addr1, prg_data1}), 0);
    @(negedge clk) rst_n = 1'b1;

    // Ascending fill, clean read-back
    for (int i = 0; i < 16; i++) begin bytes[i] = 8'(i); stall[i] = 0; end
    run_load(-1, -1, 1, n_end);
    check_writes(16);
    check_reads(16);
    check("a_done_cycle", 32'(n_end), 32'(accept_cycle(15) + 18));
    check("a_flags", 32'({done, error, busy}), 32'(3'b100));

    // Read-back corruption at address 7, restarted from DONE
    corrupt_en = 1'b1;
    run_load(-1, -1, 1, n_end);
    corrupt_en = 1'b0;
    check_writes(16);
    check_reads(8);
    check("b_err_cycle", 32'(n_end), 32'(accept_cycle(15) + 3 + 7));
    check("b_flags", 32'({done, error, busy, re_en}), 32'(4'b0100));
    check("b_err_addr", 32'(err_addr), 7);

    // Random data, random stalls, 5-cycle source gap after byte 3, start held while busy
    for (int i = 0; i < 16; i++) begin
      bytes[i] = 8'($urandom);
      stall[i] = (i == 0) ? 0 : int'($urandom_range(0, 3));
    end
    stall[4] = 5;
    run_load(-1, -1, 20, n_end);
    check_writes(16);
    check_reads(16);
    check("c_stall_gap", 32'(wr_cyc_q[4] - wr_cyc_q[3]), 6);
    check("c_done_cycle", 32'(n_end), 32'(accept_cycle(15) + 18));
    check("c_flags", 32'({done, error, busy}), 32'(3'b100));

    // Abort on the handshake for byte 9
    for (int i = 0; i < 16; i++) begin bytes[i] = 8'($urandom); stall[i] = 0; end
    run_load(9, -1, 1, n_end);
    check_writes(9);
    check_reads(0);
    check("d_idle", 32'({in_ready, prg_mode, wr_en, re_en, busy, done, error}), 0);

    // Reset pulse while verifying address 5
    run_load(-1, 5, 1, n_end);
    check_writes(16);
    check_reads(6);
    check("e_idle", 32'({in_ready, prg_mode, wr_en, re_en, busy, done, error}), 0);
    check("e_regs", 32'({address, err_addr}), 0);

    // No-verify variant, 0xA5 fill
    @(negedge clk);
    start1 = 1'b1; in_valid1 = 1'b1; in_data1 = 8'hA5;
    n = 0; w = 0; last_w = 0; re_seen = 0; a5_ok = 0;
    while (!done1 && n < 200) begin
      @(negedge clk);
      n++;
      start1 = 1'b0;
      if (wr_en1) begin
        w++; last_w = n;
        if (prg_data1 == 8'hA5 && int'(address1) == w - 1) a5_ok++;
      end
      if (re_en1) re_seen++;
    end
    in_valid1 = 1'b0;
    check("nv_done", 32'(done1), 1);
    check("nv_wr_count", 32'(w), 16);
    check("nv_wr_payload", 32'(a5_ok), 16);
    check("nv_re_never", 32'(re_seen), 0);
    check("nv_done_gap", 32'(n - last_w), 1);
    check("nv_done_cycle", 32'(n), 33);

    check("wr_re_overlap", 32'(overlap), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
